// File: rtl/chip_chk_pkg.sv
// chip_chk_pkg
//   Types and helpers used by the mux-chip checker.
//   - state_t      : sequencer states (idle, drive, settle, compare, done)
//   - expected_bit : expected output of one mux channel, for plain (74157-style)
//                    or inverting (74158-style) parts
package chip_chk_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  // A disabled part (strobe high) forces its true output low.
  // An inverting part flips that result.
  function automatic logic expected_bit(input logic invert,
                                        input logic strobe,
                                        input logic data_bit);
    return invert ^ (strobe ? 1'b0 : data_bit);
  endfunction

endpackage

// File: rtl/chip_chk_sync.sv
// chip_chk_sync
//   Two-flop synchroniser for a bus of asynchronous inputs.
//   Ports:
//     clk  in         sampling clock
//     rst  in         asynchronous active-high reset, clears both stages
//     d    in  WIDTH  asynchronous input
//     q    out WIDTH  synchronised output, two clock edges behind d
module chip_chk_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/chip_mux_checker.sv
// chip_mux_checker
//   Exhaustive tester for a 74157/74158/74153-style multiplexer chip.
//   It sweeps every {Strobe, Sel, DataIn} combination onto the chip pins.
//   After each vector settles, it compares the chip outputs with the
//   expected mux function. It reports pass/fail and the first failing vector.
//   Ports:
//     Clk        in   1         sole clock, rising edge
//     Reset      in   1         asynchronous active-high reset
//     Run        in   1         start request, sampled while idle
//     DISP_RSLT  in   1         result-displayed acknowledge, ends DONE
//     Strobe     out  1         chip enable pin, active low
//     Sel        out  SEL_W     chip select pins
//     DataIn     out  DATA_W    chip data pins, channel c input s at c*NIN+s
//     DataOut    in   CHANNELS  chip outputs, asynchronous
//     Done       out  1         high while the result is being presented
//     RSLT       out  1         1 = every checked vector matched
//     FailVec    out  VEC_W     first failing vector, all-ones if none failed
//   SETTLE must be at least 3. That lets the chip output pass through the
//   two-flop synchroniser before the compare.
module chip_mux_checker
  import chip_chk_pkg::*;
#(
  parameter  int CHANNELS     = 4,
  parameter  int SEL_W        = 1,
  parameter  int INVERT       = 0,
  parameter  int SETTLE       = 3,
  parameter  int STOP_ON_FAIL = 0,
  localparam int NIN          = 2 ** SEL_W,
  localparam int DATA_W       = CHANNELS * NIN,
  localparam int VEC_W        = 1 + SEL_W + DATA_W
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Run,
  input  logic                DISP_RSLT,
  output logic                Strobe,
  output logic [SEL_W-1:0]    Sel,
  output logic [DATA_W-1:0]   DataIn,
  input  logic [CHANNELS-1:0] DataOut,
  output logic                Done,
  output logic                RSLT,
  output logic [VEC_W-1:0]    FailVec
);

  localparam int CNT_W = $clog2(SETTLE + 1);

  state_t              state;
  state_t              next_state;
  logic [VEC_W-1:0]    vec;
  logic [CNT_W-1:0]    settle_cnt;
  logic [CHANNELS-1:0] dout_sync;
  logic [CHANNELS-1:0] expected;
  logic                mismatch;
  logic                settle_done;
  logic                last_vec;
  logic                start_run;
  logic                load_pins;
  logic                do_check;
  logic                inc_vec;

  chip_chk_sync #(.WIDTH(CHANNELS)) u_sync (
    .clk (Clk),
    .rst (Reset),
    .d   (DataOut),
    .q   (dout_sync)
  );

  // The expected value comes from the pins actually being driven, not from
  // the vector counter. That keeps it aligned with what the chip sees.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_exp
    logic [NIN-1:0] group;
    assign group       = DataIn[c*NIN +: NIN];
    assign expected[c] = expected_bit(INVERT != 0, Strobe, group[Sel]);
  end

  assign mismatch    = (dout_sync != expected);
  assign last_vec    = &vec;
  assign settle_done = (settle_cnt == CNT_W'(SETTLE - 1));

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and datapath control strobes.
  // Each vector takes one SET cycle, SETTLE settle cycles and one CHECK cycle.
  always_comb begin
    next_state = state;
    start_run  = 1'b0;
    load_pins  = 1'b0;
    do_check   = 1'b0;
    inc_vec    = 1'b0;
    Done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (Run) begin
          start_run  = 1'b1;
          next_state = S_SET;
        end
      end
      S_SET: begin
        load_pins  = 1'b1;
        next_state = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_done) begin
          next_state = S_CHECK;
        end
      end
      S_CHECK: begin
        do_check = 1'b1;
        if (last_vec || (mismatch && (STOP_ON_FAIL != 0))) begin
          next_state = S_DONE;
        end else begin
          inc_vec    = 1'b1;
          next_state = S_SET;
        end
      end
      S_DONE: begin
        Done = 1'b1;
        // Requiring Run low means a held Run can never start a second sweep.
        if (DISP_RSLT && !Run) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Vector counter, pin drivers, settle counter and result registers.
  // While RSLT is still 1 during a compare, no mismatch has been seen yet.
  // That makes RSLT the first-failure flag for FailVec.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vec        <= '0;
      Strobe     <= 1'b1;
      Sel        <= '0;
      DataIn     <= '0;
      settle_cnt <= '0;
      RSLT       <= 1'b0;
      FailVec    <= '1;
    end else begin
      if (start_run) begin
        vec     <= '0;
        RSLT    <= 1'b1;
        FailVec <= '1;
      end
      if (load_pins) begin
        {Strobe, Sel, DataIn} <= vec;
        settle_cnt            <= '0;
      end else if (state == S_SETTLE) begin
        settle_cnt <= settle_cnt + CNT_W'(1);
      end
      if (do_check && mismatch) begin
        RSLT <= 1'b0;
        if (RSLT) begin
          FailVec <= vec;
        end
      end
      if (inc_vec) begin
        vec <= vec + VEC_W'(1);
      end
    end
  end

endmodule
